unary_rate_gen: RTL and testbench

- Binary-to-unary-rate encoder: the producer end of the unary-rate bitstream consumed by the PE accumulator.
- Accepts one signed operand per valid/ready handshake and splits it into sign and magnitude.
- Emits a deterministic rate-coded bitstream of L = 2^(DATA_W-1) cycles whose count of ones equals the magnitude.
- Each stream is framed with first/last markers so the downstream PE can drive its enable, accumulate and clear controls.

---
 rtl/unary_rate_gen.sv | 140 ++++++++++++++
 tb/tb_unary_rate_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/unary_rate_gen.sv
// -----------------------------------------------------------------------------
// unary_rate_gen
//   Binary-to-unary-rate encoder feeding the PE accumulator. Each accepted
//   signed operand becomes a framed bitstream of L = 2^(DATA_W-1) valid cycles
//   whose count of ones equals the operand magnitude. The sign travels
//   alongside on out_sign. The ones are spread evenly by comparing the
//   magnitude against a bit-reversed cycle counter.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake
//   in_data [DATA_W]      signed two's-complement operand
//   in_first              operand opens a new accumulation chain
//   stall                 downstream hold; freezes the stream
//   flush                 synchronous abort of the current stream
//   out_vld               out_bit / out_sign valid this cycle
//   out_bit               unary-rate data bit
//   out_sign              operand sign (1 = negative)
//   out_first             first stream cycle of an in_first operand
//   out_last              final stream cycle
//   out_sat               operand was the most negative value (magnitude clipped)
// -----------------------------------------------------------------------------
module unary_rate_gen #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_first,
    input  logic              stall,
    input  logic              flush,
    output logic              out_vld,
    output logic              out_bit,
    output logic              out_sign,
    output logic              out_first,
    output logic              out_last,
    output logic              out_sat
);

    localparam int MAG_W = DATA_W - 1;
    localparam logic [MAG_W-1:0] CNT_MAX = '1;   // L-1

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [MAG_W-1:0] cnt_reg, cnt_next;
    logic [MAG_W-1:0] mag_reg, mag_next;
    logic             sign_reg, sign_next;
    logic             first_reg, first_next;
    logic             sat_reg, sat_next;

    logic             at_end;
    logic             accept;
    logic             is_min;
    logic [MAG_W-1:0] abs_mag;
    logic [MAG_W-1:0] rng;

    assign at_end = (cnt_reg == CNT_MAX);
    assign accept = in_valid & in_ready;

    // Magnitude in MAG_W bits. For the most negative operand the negation wraps
    // to zero, so it is replaced by the largest representable magnitude.
    assign is_min  = in_data[DATA_W-1] & ~(|in_data[MAG_W-1:0]);
    assign abs_mag = in_data[DATA_W-1] ? ((~in_data[MAG_W-1:0]) + MAG_W'(1))
                                       : in_data[MAG_W-1:0];

    // Bit-reversed counter: visits every value 0..L-1 once per stream and
    // interleaves them so the ones are spread evenly over the stream.
    genvar gi;
    generate
        for (gi = 0; gi < MAG_W; gi++) begin : g_rev
            assign rng[gi] = cnt_reg[MAG_W-1-gi];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            mag_reg   <= '0;
            sign_reg  <= 1'b0;
            first_reg <= 1'b0;
            sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mag_reg   <= mag_next;
            sign_reg  <= sign_next;
            first_reg <= first_next;
            sat_reg   <= sat_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mag_next   = mag_reg;
        sign_next  = sign_reg;
        first_next = first_reg;
        sat_next   = sat_reg;

        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (accept) begin
            // Covers both IDLE and the zero-gap reload on the last cycle.
            state_next = STREAM;
            cnt_next   = '0;
            mag_next   = is_min ? '1 : abs_mag;
            sign_next  = in_data[DATA_W-1];
            first_next = in_first;
            sat_next   = is_min;
        end else if (state_reg == STREAM && !stall) begin
            if (at_end) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + MAG_W'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        // in_ready is held low while reset is asserted.
        in_ready  = rst_n & ~flush &
                    ((state_reg == IDLE) | ((state_reg == STREAM) & at_end & ~stall));
        out_vld   = (state_reg == STREAM) & ~stall;
        out_bit   = out_vld & (mag_reg > rng);
        out_sign  = out_vld & sign_reg;
        out_sat   = out_vld & sat_reg;
        out_first = out_vld & (cnt_reg == '0) & first_reg;
        out_last  = out_vld & at_end;
    end

endmodule

// File: tb/tb_unary_rate_gen.sv
module tb_unary_rate_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_first, stall, flush;
    logic [7:0] in_data;
    logic       out_vld, out_bit, out_sign, out_first, out_last, out_sat;

    int errors = 0;
    int checks = 0;

    unary_rate_gen #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_first (in_first),
        .stall    (stall),
        .flush    (flush),
        .out_vld  (out_vld),
        .out_bit  (out_bit),
        .out_sign (out_sign),
        .out_first(out_first),
        .out_last (out_last),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       first;
        int         mag;
        logic       sign;
        logic       sat;
    } vec_t;

    vec_t vecs[6];

    // Stream statistics gathered by measure()
    int m_ones, m_vld, m_last, m_last_end, m_first0, m_bit0;
    int m_sign_bad, m_sat_bad, m_pat_err, m_ready_early, m_ready_end;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int bitrev7(input int v);
        int r = 0;
        for (int b = 0; b < 7; b++)
            if (v[b]) r = r | (1 << (6 - b));
        return r;
    endfunction

    // Samples n consecutive cycles starting at the current negedge.
    task automatic measure(input int n, input int exp_mag, input logic exp_sign,
                           input logic exp_sat);
        m_ones = 0; m_vld = 0; m_last = 0; m_last_end = 0; m_first0 = 0; m_bit0 = 0;
        m_sign_bad = 0; m_sat_bad = 0; m_pat_err = 0; m_ready_early = 0; m_ready_end = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (out_vld === 1'b1)  m_vld++;
            if (out_bit === 1'b1)  m_ones++;
            if (out_last === 1'b1) m_last++;
            if (out_sign !== exp_sign) m_sign_bad++;
            if (out_sat !== exp_sat)   m_sat_bad++;
            if (out_bit !== ((exp_mag > bitrev7(i)) ? 1'b1 : 1'b0)) m_pat_err++;
            if (i == 0) begin
                m_first0 = (out_first === 1'b1) ? 1 : 0;
                m_bit0   = (out_bit === 1'b1) ? 1 : 0;
            end
            if (i < n - 1 && in_ready === 1'b1) m_ready_early++;
            if (i == n - 1) begin
                m_last_end  = (out_last === 1'b1) ? 1 : 0;
                m_ready_end = (in_ready === 1'b1) ? 1 : 0;
            end
        end
    endtask

    task automatic offer(input logic [7:0] d, input logic f);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_first = f;
        #1;
        check("ready_before_accept", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic int outs_vec();
        return int'({out_vld, out_bit, out_sign, out_first, out_last, out_sat, in_ready});
    endfunction

    initial begin
        int vld_c, ones_c, last_c, last_cyc, stall_vld, stall_rdy;

        vecs[0] = '{8'd5,   1'b1, 5,   1'b0, 1'b0};
        vecs[1] = '{8'd64,  1'b0, 64,  1'b0, 1'b0};
        vecs[2] = '{8'h80,  1'b1, 127, 1'b1, 1'b1};
        vecs[3] = '{8'd0,   1'b0, 0,   1'b0, 1'b0};
        vecs[4] = '{8'hFF,  1'b1, 1,   1'b1, 1'b0};
        vecs[5] = '{8'd127, 1'b0, 127, 1'b0, 1'b0};

        in_valid = 0; in_data = 0; in_first = 0; stall = 0; flush = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", outs_vec(), 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", int'(in_ready), 1);

        // Table-driven single streams
        for (int v = 0; v < 6; v++) begin
            offer(vecs[v].data, vecs[v].first);
            measure(128, vecs[v].mag, vecs[v].sign, vecs[v].sat);
            check("vld_count", m_vld, 128);
            check("ones", m_ones, vecs[v].mag);
            check("last_count", m_last, 1);
            check("last_on_128", m_last_end, 1);
            check("first_cycle0", m_first0, int'(vecs[v].first));
            check("bit_cycle0", m_bit0, (vecs[v].mag > 0) ? 1 : 0);
            check("sign_held", m_sign_bad, 0);
            check("sat_held", m_sat_bad, 0);
            check("bit_pattern", m_pat_err, 0);
            check("ready_low_mid", m_ready_early, 0);
            check("ready_on_last", m_ready_end, 1);
            @(negedge clk); #1;
            check("idle_after", int'(out_vld), 0);
            $display("vector %0d data=%0d: ones=%0d vld=%0d", v, $signed(vecs[v].data), m_ones, m_vld);
        end

        // Back-to-back +3 then -7 with in_valid held
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd3; in_first = 1'b1;
        @(negedge clk);
        in_data = 8'hF9; in_first = 1'b0;
        measure(128, 3, 1'b0, 1'b0);
        check("b2b_s1_ones", m_ones, 3);
        check("b2b_s1_last", m_last_end, 1);
        check("b2b_s1_ready_end", m_ready_end, 1);
        @(negedge clk);
        in_valid = 1'b0;
        measure(128, 7, 1'b1, 1'b0);
        check("b2b_s2_vld", m_vld, 128);
        check("b2b_s2_ones", m_ones, 7);
        check("b2b_s2_first", m_first0, 0);
        check("b2b_s2_sign", m_sign_bad, 0);
        check("b2b_s2_last", m_last_end, 1);
        @(negedge clk); #1;
        check("b2b_idle_after", int'(out_vld), 0);
        $display("back-to-back: second stream ones=%0d vld=%0d", m_ones, m_vld);

        // Stall for 10 cycles at cnt=40
        offer(8'd100, 1'b0);
        vld_c = 0; ones_c = 0; last_c = 0; last_cyc = -1; stall_vld = 0; stall_rdy = 0;
        for (int c = 0; c < 138; c++) begin
            if (c > 0) @(negedge clk);
            stall = (c >= 40 && c < 50);
            #1;
            if (out_vld === 1'b1) vld_c++;
            if (out_bit === 1'b1) ones_c++;
            if (out_last === 1'b1) begin last_c++; last_cyc = c; end
            if (stall && out_vld !== 1'b0) stall_vld++;
            if (stall && in_ready !== 1'b0) stall_rdy++;
        end
        stall = 1'b0;
        check("stall_vld", vld_c, 128);
        check("stall_ones", ones_c, 100);
        check("stall_last_count", last_c, 1);
        check("stall_last_cycle", last_cyc, 137);
        check("stall_no_vld", stall_vld, 0);
        check("stall_no_ready", stall_rdy, 0);
        $display("stall run: ones=%0d vld=%0d last_at=%0d", ones_c, vld_c, last_cyc);

        // Flush at cnt=20, with a competing in_valid
        @(negedge clk);
        offer(8'd100, 1'b0);
        measure(20, 100, 1'b0, 1'b0);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'd5;
        #1;
        check("flush_cycle_vld", int'(out_vld), 1);
        check("flush_cycle_ready", int'(in_ready), 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_idle_vld", int'(out_vld), 0);
        check("flush_idle_ready", int'(in_ready), 1);
        stall = 1'b1; #1;
        check("stall_in_idle_ready", int'(in_ready), 1);
        stall = 1'b0;
        vld_c = 0; last_c = 0;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk); #1;
            if (out_vld === 1'b1) vld_c++;
            if (out_last === 1'b1) last_c++;
        end
        check("flush_no_vld", vld_c, 0);
        check("flush_no_last", last_c, 0);
        $display("flush run: vld after flush=%0d last=%0d", vld_c, last_c);

        // Asynchronous reset mid-stream
        offer(8'd100, 1'b1);
        measure(20, 100, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", outs_vec(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mid_ready", int'(in_ready), 1);
        vld_c = 0; last_c = 0;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk); #1;
            if (out_vld === 1'b1) vld_c++;
            if (out_last === 1'b1) last_c++;
        end
        check("rst_no_vld", vld_c, 0);
        check("rst_no_last", last_c, 0);
        $display("reset run: vld after reset=%0d last=%0d", vld_c, last_c);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
